// File: rtl/data_memory.sv
// Line-organised data memory with a fixed request-to-ack latency.
// One request at a time: addr/data/write are latched on acceptance, ack_o
// pulses for one cycle LATENCY cycles later, and a write commits on the edge
// that ends the ack cycle. Read data is visible on data_o only during ack.
// Optional macro DMEM_ADDR_CHECK_EN: requests with address bits above the
// array range complete normally but neither write memory nor return data.
module data_memory #(
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned MEM_DEPTH  = 512,
  parameter int unsigned LATENCY    = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [31:0]           addr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  enable_i,
  input  logic                  write_i,
  output logic                  ack_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  localparam int unsigned IdxW = $clog2(MEM_DEPTH);
  // Counter value one cycle before the ack cycle; unused when LATENCY == 1.
  localparam logic [7:0] PreAck = 8'(LATENCY - 2);
  localparam logic       AckOnAccept = (LATENCY == 1);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  logic [DATA_WIDTH-1:0] memory [MEM_DEPTH];

  state_e                state_q;
  logic [7:0]            cnt_q;
  logic [IdxW-1:0]       idx_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  write_q;
  logic                  ack_q;
  logic                  blocked;

  // Byte offset within a line never selects anything.
  logic unused_addr;
  assign unused_addr = ^{addr_i[4:0], addr_i[31:5+IdxW]};

  // Request FSM: latch on acceptance, count, raise ack from a flop in the last cycle
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      write_q <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          ack_q <= 1'b0;
          if (enable_i) begin
            idx_q   <= addr_i[5 +: IdxW];
            data_q  <= data_i;
            write_q <= write_i;
            cnt_q   <= '0;
            state_q <= StWait;
            ack_q   <= AckOnAccept;
          end
        end
        StWait: begin
          cnt_q <= cnt_q + 8'd1;
          if (ack_q) begin
            state_q <= StIdle;
            ack_q   <= 1'b0;
          end else begin
            ack_q <= (cnt_q == PreAck);
          end
        end
        default: begin
          state_q <= StIdle;
          ack_q   <= 1'b0;
        end
      endcase
    end
  end

`ifdef DMEM_ADDR_CHECK_EN
  logic blocked_q;

  // Remember whether the accepted address lies outside the array
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      blocked_q <= 1'b0;
    end else if (state_q == StIdle && enable_i) begin
      blocked_q <= |addr_i[31:5+IdxW];
    end
  end

  assign blocked = blocked_q;
`else
  assign blocked = 1'b0;
`endif

  // Commit a latched write on the edge that closes the ack cycle; no reset on storage
  always_ff @(posedge clk_i) begin
    if (state_q == StWait && ack_q && write_q && !blocked) begin
      memory[idx_q] <= data_q;
    end
  end

  // Read data is only presented during the ack cycle of a read
  always_comb begin
    data_o = '0;
    if (ack_q && !write_q && !blocked) begin
      data_o = memory[idx_q];
    end
  end

  assign ack_o = ack_q;

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory with a line-array reference model.
module tb_data_memory;

  localparam int Lat   = 10;
  localparam int Depth = 512;

  logic         clk_i;
  logic         rst_i;
  logic [31:0]  addr_i;
  logic [255:0] data_i;
  logic         enable_i;
  logic         write_i;
  logic         ack_o;
  logic [255:0] data_o;

  logic [255:0] ref_mem [Depth];
  int n_pass;
  int n_total;

  data_memory dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .addr_i   (addr_i),
    .data_i   (data_i),
    .enable_i (enable_i),
    .write_i  (write_i),
    .ack_o    (ack_o),
    .data_o   (data_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic int line_of(input logic [31:0] a);
    return int'((a >> 5) % Depth);
  endfunction

  function automatic bit out_of_range(input logic [31:0] a);
`ifdef DMEM_ADDR_CHECK_EN
    return (a >= 32'h4000);
`else
    return (a != a) ? 1'b1 : 1'b0;
`endif
  endfunction

  // Issue one request from a negedge; scrambles the inputs while waiting.
  task automatic run_req(input logic [31:0] a, input logic [255:0] d, input logic w,
                         output int lat, output logic [255:0] rd, output logic ack_after);
    addr_i   = a;
    data_i   = d;
    write_i  = w;
    enable_i = 1'b1;
    @(posedge clk_i);
    lat = -1;
    rd  = '0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk_i);
      if (ack_o) begin
        lat      = c;
        rd       = data_o;
        enable_i = 1'b0;
        break;
      end
      addr_i  = $urandom;
      data_i  = rand256();
      write_i = 1'($urandom_range(0, 1));
    end
    enable_i = 1'b0;
    @(negedge clk_i);
    ack_after = ack_o;
  endtask

  task automatic test_reset();
    rst_i    = 1'b0;
    enable_i = 1'b0;
    #1;
    n_total++;
    if (ack_o !== 1'b0) $display("FAIL reset_ack got=%b want=0", ack_o);
    else n_pass++;
    n_total++;
    if (data_o !== '0) $display("FAIL reset_data got=%h want=0", data_o);
    else n_pass++;
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_basic_read();
    int lat;
    logic [255:0] rd;
    logic nxt;
    rst_i = 1'b0;
    dut.memory[0] = 256'h5;
    ref_mem[0]    = 256'h5;
    @(negedge clk_i);
    rst_i = 1'b1;
    run_req(32'h0, rand256(), 1'b0, lat, rd, nxt);
    n_total++;
    if (lat !== Lat) $display("FAIL read0_latency got=%0d want=%0d", lat, Lat);
    else n_pass++;
    n_total++;
    if (rd !== 256'h5) $display("FAIL read0_data got=%h want=%h", rd, 256'h5);
    else n_pass++;
    n_total++;
    if (nxt !== 1'b0) $display("FAIL read0_ack_single got=%b want=0", nxt);
    else n_pass++;
  endtask

  task automatic test_write_read();
    int lat;
    logic [255:0] rd;
    logic nxt;
    logic [255:0] pat;
    pat = {32{8'hA5}};
    run_req(32'h20, pat, 1'b1, lat, rd, nxt);
    ref_mem[1] = pat;
    n_total++;
    if (lat !== Lat) $display("FAIL write1_latency got=%0d want=%0d", lat, Lat);
    else n_pass++;
    n_total++;
    if (dut.memory[1] !== pat) $display("FAIL write1_mem got=%h want=%h", dut.memory[1], pat);
    else n_pass++;
    n_total++;
    if (dut.memory[0] !== ref_mem[0])
      $display("FAIL write1_mem0 got=%h want=%h", dut.memory[0], ref_mem[0]);
    else n_pass++;
    n_total++;
    if (rd !== '0) $display("FAIL write1_data_zero got=%h want=0", rd);
    else n_pass++;
    run_req(32'h20, rand256(), 1'b0, lat, rd, nxt);
    n_total++;
    if (rd !== pat) $display("FAIL read1_data got=%h want=%h", rd, pat);
    else n_pass++;
  endtask

  task automatic test_line_offset();
    int lat;
    logic [255:0] rd;
    logic nxt;
    dut.memory[32] = 256'h1234;
    ref_mem[32]    = 256'h1234;
    run_req(32'h400, rand256(), 1'b0, lat, rd, nxt);
    n_total++;
    if (rd !== 256'h1234) $display("FAIL read32_data got=%h want=%h", rd, 256'h1234);
    else n_pass++;
    run_req(32'h40C, rand256(), 1'b0, lat, rd, nxt);
    n_total++;
    if (rd !== 256'h1234) $display("FAIL read32_offset got=%h want=%h", rd, 256'h1234);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int acks [$];
    addr_i   = 32'h40;
    data_i   = rand256();
    write_i  = 1'b0;
    enable_i = 1'b1;
    @(posedge clk_i);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk_i);
      if (ack_o) begin
        acks.push_back(c);
        if (acks.size() == 3) enable_i = 1'b0;
      end
    end
    enable_i = 1'b0;
    n_total++;
    if (acks.size() != 3) $display("FAIL b2b_count got=%0d want=3", acks.size());
    else n_pass++;
    for (int i = 0; i < 3 && i < acks.size(); i++) begin
      n_total++;
      if (acks[i] != Lat + i * (Lat + 1))
        $display("FAIL b2b_ack%0d got=%0d want=%0d", i, acks[i], Lat + i * (Lat + 1));
      else n_pass++;
    end
  endtask

  task automatic test_reset_pending();
    int lat;
    int seen;
    logic [255:0] rd;
    logic nxt;
    seen     = 0;
    addr_i   = 32'h20;
    data_i   = rand256();
    write_i  = 1'b1;
    enable_i = 1'b1;
    @(posedge clk_i);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk_i);
      if (ack_o) seen++;
    end
    rst_i    = 1'b0;
    enable_i = 1'b0;
    #1;
    n_total++;
    if (ack_o !== 1'b0 || data_o !== '0)
      $display("FAIL async_reset got=%b/%h want=0/0", ack_o, data_o);
    else n_pass++;
    @(negedge clk_i);
    rst_i = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_i);
      if (ack_o) seen++;
    end
    n_total++;
    if (seen != 0) $display("FAIL reset_no_ack got=%0d want=0", seen);
    else n_pass++;
    n_total++;
    if (dut.memory[1] !== ref_mem[1])
      $display("FAIL reset_discard got=%h want=%h", dut.memory[1], ref_mem[1]);
    else n_pass++;
    run_req(32'h20, rand256(), 1'b0, lat, rd, nxt);
    n_total++;
    if (lat !== Lat || rd !== ref_mem[1])
      $display("FAIL post_reset_req got=%0d/%h want=%0d/%h", lat, rd, Lat, ref_mem[1]);
    else n_pass++;
  endtask

  task automatic test_random();
    int lat;
    int bad;
    logic [255:0] rd;
    logic [255:0] d;
    logic [255:0] exp;
    logic nxt;
    logic [31:0] a;
    logic w;
    for (int t = 0; t < 40; t++) begin
      a = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 32'h3FFF)) : $urandom;
      w = 1'($urandom_range(0, 1));
      d = rand256();
      exp = (w || out_of_range(a)) ? '0 : ref_mem[line_of(a)];
      run_req(a, d, w, lat, rd, nxt);
      if (w && !out_of_range(a)) ref_mem[line_of(a)] = d;
      n_total++;
      if (lat !== Lat || rd !== exp || nxt !== 1'b0)
        $display("FAIL rand%0d addr=%h got=%0d/%h/%b want=%0d/%h/0",
                 t, a, lat, rd, nxt, Lat, exp);
      else n_pass++;
    end
    bad = 0;
    for (int i = 0; i < Depth; i++) if (dut.memory[i] !== ref_mem[i]) bad++;
    n_total++;
    if (bad != 0) $display("FAIL mem_sweep got=%0d bad lines want=0", bad);
    else n_pass++;
  endtask

  task automatic test_addr_check();
    int lat;
    logic [255:0] rd;
    logic [255:0] d;
    logic nxt;
    d = rand256();
    run_req(32'h4000, d, 1'b1, lat, rd, nxt);
    if (!out_of_range(32'h4000)) ref_mem[0] = d;
    n_total++;
    if (lat !== Lat) $display("FAIL hiaddr_latency got=%0d want=%0d", lat, Lat);
    else n_pass++;
    n_total++;
    if (dut.memory[0] !== ref_mem[0])
      $display("FAIL hiaddr_mem0 got=%h want=%h", dut.memory[0], ref_mem[0]);
    else n_pass++;
    run_req(32'h4000, rand256(), 1'b0, lat, rd, nxt);
    n_total++;
    if (rd !== (out_of_range(32'h4000) ? 256'h0 : ref_mem[0]))
      $display("FAIL hiaddr_read got=%h", rd);
    else n_pass++;
  endtask

  initial begin
    n_pass   = 0;
    n_total  = 0;
    rst_i    = 1'b0;
    enable_i = 1'b0;
    write_i  = 1'b0;
    addr_i   = '0;
    data_i   = '0;
    for (int i = 0; i < Depth; i++) begin
      ref_mem[i]    = rand256();
      dut.memory[i] = ref_mem[i];
    end
    test_reset();
    test_basic_read();
    test_write_read();
    test_line_offset();
    test_back_to_back();
    test_reset_pending();
    test_random();
    test_addr_check();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 256: line width in bits.
REQ-002 SHALL have parameter MEM_DEPTH, default 512: number of lines (16 KB total).
REQ-003 SHALL have parameter LATENCY, default 10: cycles from request acceptance to ack; legal range 1..255.
REQ-004 SHALL have port clk_i, input, 1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_i, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port addr_i, input, 32: byte address; line index = addr_i[13:5]; addr_i[4:0] ignored.
REQ-007 SHALL have port data_i, input, DATA_WIDTH: write line data.
REQ-008 SHALL have port enable_i, input, 1: request valid; held high by the requestor until ack_o.
REQ-009 SHALL have port write_i, input, 1: 1 = write, 0 = read; sampled with enable_i.
REQ-010 SHALL have port ack_o, output, 1: request complete, high for exactly one cycle.
REQ-011 SHALL have port data_o, output, DATA_WIDTH: read line data.
REQ-012 SHALL hold storage in an array named memory, MEM_DEPTH x DATA_WIDTH, index 0 = byte address 0x0000, so benches can preload and inspect it hierarchically.

Function
REQ-013 SHALL implement a two-state FSM: IDLE, WAIT.
REQ-014 In IDLE with enable_i high at a rising edge, SHALL latch addr_i, data_i and write_i, enter WAIT and clear the counter to 0.
REQ-015 In IDLE with enable_i low, SHALL remain in IDLE; ack_o low.
REQ-016 In WAIT, SHALL increment the counter each edge and ignore changes on addr_i, data_i, write_i and enable_i.
REQ-017 SHALL drive ack_o high only while state = WAIT and counter = LATENCY-1, i.e. in the LATENCY-th cycle after the acceptance edge; ack_o SHALL be decoded from flops only (glitch-free).
REQ-018 On the edge that ends the ack cycle, a latched write SHALL commit the latched data to memory[latched index]; the FSM SHALL return to IDLE.
REQ-019 For a read, data_o SHALL equal memory[latched index] during the ack cycle; outside ack cycles data_o SHALL be all zeros.
REQ-020 If enable_i is still high in the first IDLE cycle after an ack, SHALL accept it as a new request (back-to-back spacing LATENCY+1 cycles).
REQ-021 Reads SHALL NOT modify memory; write data SHALL be stored full-width with no masking.
REQ-022 Without DMEM_ADDR_CHECK_EN, address bits above bit 13 SHALL be ignored (index wraps modulo MEM_DEPTH).

Reset
REQ-023 rst_i low SHALL immediately force state IDLE, counter 0, ack_o 0 and data_o 0, independent of clk_i.
REQ-024 Reset SHALL NOT alter memory contents; a write pending at reset SHALL be discarded.
REQ-025 After rst_i rises, the first request SHALL be accepted no earlier than the next rising edge.

Configuration
REQ-026 With macro DMEM_ADDR_CHECK_EN defined, a request with addr_i[31:14] nonzero SHALL still complete with a normal ack after LATENCY cycles, SHALL NOT write memory, and SHALL return all-zero data_o.
REQ-027 Without DMEM_ADDR_CHECK_EN, the behaviour of REQ-022 SHALL apply and no range checking logic SHALL be present.

Verification
REQ-028 Preload memory[0] = 0x5, hold rst_i low 1 cycle, then read addr 0x0000 -> ack_o high exactly in the 10th cycle after acceptance, data_o = 0x...05, ack_o low in the next cycle.
REQ-029 Write addr 0x0020 with data 0xA5A5...A5, then read 0x0020 -> memory[1] = 0xA5A5...A5 after the write ack, read returns the same value; memory[0] unchanged.
REQ-030 Read addr 0x0400 after preloading memory[32] = 0x1234 -> data_o = 0x1234 at ack; read addr 0x040C returns the same line.
REQ-031 Hold enable_i high continuously with write_i = 0 -> acks in cycles 10, 21 and 32 after the first acceptance edge; no ack in between.
REQ-032 Start a write to 0x0020 and pull rst_i low when the counter reaches 5 -> ack_o never asserts, memory[1] keeps its old value, and a new request after reset completes in 10 cycles.
REQ-033 With DMEM_ADDR_CHECK_EN defined, write to 0x0000_4000 -> ack after 10 cycles, memory[0] unchanged; without the macro the same write updates memory[0].
